// File: rtl/alu_sequencer.sv
// alu_sequencer: fetch/execute controller that owns a 4x8 register file and drives an external 8-bit ALU.
// Optional feature macro: SEQ_BRANCH_EN (BRZ/JMP taken when defined; otherwise they execute as NOPs).
module alu_sequencer (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  output logic [7:0]  pm_addr,
  output logic        pm_rd,
  input  logic [15:0] pm_data,
  input  logic        pm_valid,
  output logic [3:0]  alu_fs,
  output logic [2:0]  alu_sh,
  output logic [7:0]  alu_a,
  output logic [7:0]  alu_b,
  input  logic [7:0]  alu_f,
  input  logic        alu_n,
  input  logic        alu_z,
  input  logic        alu_c,
  input  logic        alu_v,
  input  logic [7:0]  in_port,
  output logic [7:0]  out_port,
  output logic        out_valid,
  output logic [3:0]  flags,
  output logic        busy,
  output logic        halted
);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_EXEC, S_HALT} state_t;

  state_t      state;
  logic [7:0]  pc;
  logic [15:0] ir;
  logic [7:0]  regs [4];

  logic [3:0]  op;
  logic [1:0]  rd;
  logic [1:0]  ra;
  logic [1:0]  rb;
  logic [2:0]  sh;
  logic [7:0]  imm;

  logic        is_alu;
  logic        is_halt;
  logic        branch_taken;
  logic [7:0]  pc_next;
  logic        rf_we;
  logic [7:0]  rf_wdata;

  assign op  = ir[15:12];
  assign rd  = ir[11:10];
  assign ra  = ir[9:8];
  assign rb  = ir[7:6];
  assign sh  = ir[5:3];
  assign imm = ir[7:0];

  // The ALU is driven straight from IR and the register file in every state.
  assign pm_addr = pc;
  assign alu_fs  = op;
  assign alu_sh  = sh;
  assign alu_a   = regs[ra];
  assign alu_b   = regs[rb];

  assign is_alu  = (op <= 4'hA);
  assign is_halt = (op == 4'hF) && ir[11];

`ifdef SEQ_BRANCH_EN
  assign branch_taken = ((op == 4'hE) && flags[2]) || ((op == 4'hF) && !ir[11]);
`else
  assign branch_taken = 1'b0;
`endif

  assign pc_next = branch_taken ? imm : (pc + 8'd1);

  always_comb begin
    rf_we    = 1'b0;
    rf_wdata = alu_f;
    if (state == S_EXEC) begin
      case (op)
        4'hB: begin
          rf_we    = 1'b1;
          rf_wdata = imm;
        end
        4'hC: begin
          rf_we    = 1'b1;
          rf_wdata = in_port;
        end
        default: rf_we = is_alu;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      pc        <= 8'h00;
      ir        <= 16'h0000;
      for (int i = 0; i < 4; i++) regs[i] <= 8'h00;
      flags     <= 4'h0;
      out_port  <= 8'h00;
      out_valid <= 1'b0;
      pm_rd     <= 1'b0;
      busy      <= 1'b0;
      halted    <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      if (rf_we) regs[rd] <= rf_wdata;
      case (state)
        S_IDLE, S_HALT: begin
          if (start) begin
            state  <= S_FETCH;
            pc     <= 8'h00;
            pm_rd  <= 1'b1;
            busy   <= 1'b1;
            halted <= 1'b0;
          end
        end
        S_FETCH: begin
          if (pm_valid) begin
            ir    <= pm_data;
            pm_rd <= 1'b0;
            state <= S_EXEC;
          end
        end
        S_EXEC: begin
          pc <= pc_next;
          if (is_alu) flags <= {alu_n, alu_z, alu_c, alu_v};
          if (op == 4'hD) begin
            out_port  <= regs[ra];
            out_valid <= 1'b1;
          end
          if (is_halt) begin
            state  <= S_HALT;
            busy   <= 1'b0;
            halted <= 1'b1;
          end else begin
            state <= S_FETCH;
            pm_rd <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
